// File: rtl/l2_arbiter.sv
// L2 read-port arbiter: grants one cache requester at a time by fixed priority
// and streams a page burst from memory into the winner, one word per ready pulse.
module l2_arbiter #(
    parameter  int NREQ       = 2,
    parameter  int ADDR_WIDTH = 16,
    parameter  int PAGE_BYTES = 32,
    localparam int OW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_start,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_page,
    output logic                       l2_busy,
    output logic [NREQ-1:0]            l2_launch,
    output logic [NREQ-1:0]            l2_ready,
    output logic [15:0]                l2_data,
    output logic [OW-1:0]              owner,
    output logic                       mem_req,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    input  logic                       mem_ack,
    input  logic [15:0]                mem_data
);
    localparam int PAGE_WORDS  = PAGE_BYTES / 2;
    localparam int OFFSET_BITS = $clog2(PAGE_BYTES);
    localparam int CW          = (PAGE_WORDS > 1) ? $clog2(PAGE_WORDS) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(PAGE_WORDS - 1);

    // state | meaning
    // IDLE  | port free, waiting for any req_start
    // GUARD | two settle cycles so the grantee reaches its load state
    // FETCH | mem_req held until mem_ack
    // PULSE | one-cycle l2_ready to the owner, then next word or release
    typedef enum logic [1:0] {IDLE, GUARD, FETCH, PULSE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] page;
    logic [CW-1:0]         cnt;
    logic                  guard;

    logic                  any_start;
    logic [OW-1:0]         win;
    logic [ADDR_WIDTH-1:0] win_page;

    // Scan from the lowest priority up so the lowest set index wins.
    always_comb begin
        win      = '0;
        win_page = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_start[i]) begin
                win      = OW'(i);
                win_page = req_page[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign any_start = |req_start;

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] pg,
                                                        input logic [CW-1:0]         idx);
        return (pg << OFFSET_BITS) + (ADDR_WIDTH'(idx) << 1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            page      <= '0;
            cnt       <= '0;
            guard     <= 1'b0;
            l2_busy   <= 1'b0;
            l2_launch <= '0;
            l2_ready  <= '0;
            l2_data   <= '0;
            owner     <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
        end else begin
            l2_ready <= '0;
            case (state)
                IDLE: begin
                    if (any_start) begin
                        page      <= win_page;
                        owner     <= win;
                        l2_launch <= NREQ'(1) << win;
                        l2_busy   <= 1'b1;
                        guard     <= 1'b1;
                        cnt       <= '0;
                        state     <= GUARD;
                    end
                end
                GUARD: begin
                    if (guard) begin
                        guard <= 1'b0;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= word_addr(page, cnt);
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        l2_data  <= mem_data;
                        mem_req  <= 1'b0;
                        l2_ready <= l2_launch;
                        state    <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt == LAST_WORD) begin
                        l2_busy   <= 1'b0;
                        l2_launch <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        mem_req  <= 1'b1;
                        mem_addr <= word_addr(page, cnt + 1'b1);
                        state    <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: vector table plus hand sequences, per-requester fill
// scoreboard fed at request time and drained by a ready-pulse monitor.
module tb_l2_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 16;
    localparam int PW   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_start = '0;
    logic [NREQ*AW-1:0] req_page = '0;
    logic              l2_busy;
    logic [NREQ-1:0]   l2_launch;
    logic [NREQ-1:0]   l2_ready;
    logic [15:0]       l2_data;
    logic [0:0]        owner;
    logic              mem_req;
    logic [AW-1:0]     mem_addr;
    logic              mem_ack = 1'b0;
    logic [15:0]       mem_data = '0;

    l2_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .PAGE_BYTES(32)) dut (
        .clk(clk), .rst(rst), .req_start(req_start), .req_page(req_page),
        .l2_busy(l2_busy), .l2_launch(l2_launch), .l2_ready(l2_ready),
        .l2_data(l2_data), .owner(owner), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: data is a keyed function of the byte address.
    int          mem_wait = 0;
    logic [15:0] mem_key  = '0;
    int          wait_cnt = 0;

    function automatic logic [15:0] mem_fn(input logic [15:0] a, input logic [15:0] k);
        return a ^ k;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst || !mem_req) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (wait_cnt >= mem_wait) begin
                mem_ack  = 1'b1;
                mem_data = mem_fn(mem_addr, mem_key);
                wait_cnt = 0;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt++;
            end
        end
    end

    logic [15:0] exp_q [NREQ][$];

    task automatic push_burst(input int i, input logic [15:0] pg);
        logic [15:0] a;
        for (int w = 0; w < PW; w++) begin
            a = (pg << 5) + 16'(w * 2);
            exp_q[i].push_back(mem_fn(a, mem_key));
        end
    endtask

    // Monitor: drains the scoreboard on ready pulses and checks bus invariants.
    logic mon_en = 1'b0;
    logic prev_ready = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_ready = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
            end else begin
                check("launch_onehot", 32'($countones(l2_launch) <= 1), 1);
                check("busy_vs_launch", l2_busy, |l2_launch);
                if (l2_ready != '0) begin
                    check("ready_not_adjacent", prev_ready, 0);
                    check("ready_onehot", $countones(l2_ready), 1);
                    check("ready_within_launch", l2_ready & l2_launch, l2_ready);
                    for (int i = 0; i < NREQ; i++) begin
                        if (l2_ready[i]) begin
                            if (exp_q[i].size() == 0) begin
                                checks++; failures++;
                                $display("FAIL unexpected_ready: requester %0d data %0h, none expected", i, l2_data);
                            end else begin
                                check("fill_data", l2_data, exp_q[i].pop_front());
                            end
                        end
                    end
                end
                if (prev_req && !prev_ack) check("mem_req_held", mem_req, 1);
                prev_ready = |l2_ready;
                prev_req   = mem_req;
                prev_ack   = mem_ack;
            end
        end
    end

    int launch_cyc [NREQ];
    int last_pulse_cyc [NREQ];

    // Cache-side model: request, keep polling until launched, then collect the page.
    task automatic icache_fill(input int i, input logic [15:0] pg);
        int t, n, prevc;
        req_page[i*AW +: AW] = pg;
        req_start[i] = 1'b1;
        push_burst(i, pg);
        t = 0;
        @(negedge clk);
        while (!l2_launch[i] && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("launch_seen", l2_launch[i], 1);
        req_start[i] = 1'b0;
        if (!l2_launch[i]) begin
            exp_q[i].delete();
            return;
        end
        launch_cyc[i] = cyc;
        n = 0; t = 0; prevc = cyc;
        while (n < PW && t < 600) begin
            if (l2_ready[i]) begin
                if (n == 0) check("first_pulse_latency", cyc - launch_cyc[i], 3 + mem_wait);
                else        check("pulse_gap", cyc - prevc, 2 + mem_wait);
                prevc = cyc;
                n++;
            end
            if (n < PW) begin
                @(negedge clk);
                t++;
            end
        end
        check("pulse_count", n, PW);
        last_pulse_cyc[i] = cyc;
        @(negedge clk);
        check("busy_low_after_burst", l2_busy, 0);
        check("launch_low_after_burst", l2_launch, 0);
    endtask

    typedef struct {
        logic [1:0]  mask;
        logic [15:0] p0;
        logic [15:0] p1;
        int          wt;
        logic [15:0] key;
        logic [1:0]  exp_launch;
        logic        exp_owner;
    } vec_t;

    task automatic run_vec(input vec_t v);
        mem_wait = v.wt;
        mem_key  = v.key;
        fork
            if (v.mask[0]) icache_fill(0, v.p0);
            if (v.mask[1]) icache_fill(1, v.p1);
            begin
                @(negedge clk);
                check("grant_launch", l2_launch, v.exp_launch);
                check("grant_owner", owner, v.exp_owner);
                check("grant_busy", l2_busy, 1);
            end
        join
        check("scoreboard_drained", exp_q[0].size() + exp_q[1].size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, l2_busy, 0);
        check({tag, "_launch"}, l2_launch, 0);
        check({tag, "_ready"}, l2_ready, 0);
        check({tag, "_data"}, l2_data, 0);
        check({tag, "_owner"}, owner, 0);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs [6];
    vec_t rv;
    int   t;
    int   n;

    initial begin
        vecs[0] = '{2'b01, 16'h0012, 16'h0000, 0, 16'h0000, 2'b01, 1'b0};
        vecs[1] = '{2'b11, 16'h00A0, 16'h0155, 0, 16'h1234, 2'b01, 1'b0};
        vecs[2] = '{2'b10, 16'h0000, 16'h0FFF, 1, 16'hBEEF, 2'b10, 1'b1};
        vecs[3] = '{2'b01, 16'h0333, 16'h0000, 3, 16'h5A5A, 2'b01, 1'b0};
        vecs[4] = '{2'b11, 16'h0044, 16'h0088, 3, 16'h0F0F, 2'b01, 1'b0};
        vecs[5] = '{2'b10, 16'h0000, 16'h0201, 2, 16'hC3C3, 2'b10, 1'b1};

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k]);
            repeat (2) @(negedge clk);
        end

        // A request arriving mid-burst and withdrawn before IDLE is never granted.
        mem_wait = 0; mem_key = 16'h3C3C;
        fork
            icache_fill(0, 16'h0100);
            begin
                repeat (8) @(negedge clk);
                req_page[AW +: AW] = 16'h0200;
                req_start[1] = 1'b1;
                repeat (4) @(negedge clk);
                req_start[1] = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check("withdrawn_req_no_launch", l2_launch, 0);

        // A request held through another burst is granted right after release.
        fork
            icache_fill(0, 16'h0300);
            begin
                repeat (8) @(negedge clk);
                icache_fill(1, 16'h0400);
            end
        join
        check("held_req_grant_cycle", launch_cyc[1] - last_pulse_cyc[0], 2);
        check("scoreboard_drained_held", exp_q[0].size() + exp_q[1].size(), 0);
        repeat (2) @(negedge clk);

        // Reset during the fifth word abandons the burst.
        mem_wait = 1; mem_key = 16'h7777;
        req_page[0 +: AW] = 16'h0050;
        req_start[0] = 1'b1;
        push_burst(0, 16'h0050);
        t = 0;
        @(negedge clk);
        while (!l2_launch[0] && t < 50) begin @(negedge clk); t++; end
        check("rst_seq_launch", l2_launch[0], 1);
        req_start[0] = 1'b0;
        n = 0; t = 0;
        while (n < 4 && t < 100) begin
            @(negedge clk);
            t++;
            if (l2_ready[0]) n++;
        end
        check("rst_seq_pulses_before", n, 4);
        @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_zero("midburst_rst");
        rst = 1'b0;
        exp_q[0].delete();
        repeat (3) @(negedge clk);
        check_zero("after_rst_idle");
        mon_en = 1'b1;
        mem_key = 16'h1111;
        icache_fill(0, 16'h0050);
        check("scoreboard_drained_rst", exp_q[0].size(), 0);
        repeat (2) @(negedge clk);

        // Random misses from both caches.
        for (int k = 0; k < 12; k++) begin
            rv.mask = 2'($urandom_range(1, 3));
            rv.p0   = 16'($urandom_range(0, 16'h0FFF));
            rv.p1   = 16'($urandom_range(0, 16'h0FFF));
            rv.wt   = $urandom_range(0, 2);
            rv.key  = 16'($urandom);
            rv.exp_launch = rv.mask[0] ? 2'b01 : 2'b10;
            rv.exp_owner  = rv.mask[0] ? 1'b0 : 1'b1;
            run_vec(rv);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
